// File: rtl/m3_pkg.sv
// Shared types and constant tables for the milestone-3 lossless decoder.
// Zigzag tables give (row i, column j) for each scan index k.
package m3_pkg;

    typedef enum logic [2:0] {
        S_M3_IDLE,
        S_M3_REQ,
        S_M3_WAIT,
        S_M3_APPEND,
        S_M3_DECODE,
        S_M3_WRITE,
        S_M3_NEXT_BLOCK,
        S_M3_DONE
    } m3_state_type;

    // Dequantization shift indexed by d = i + j
    localparam logic [2:0] QSHIFT [0:14] = '{
        3'd3, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5,
        3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5
    };

    localparam logic [2:0] ZZ_I [0:63] = '{
        3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
        3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
        3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
        3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
        3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
    };

    localparam logic [2:0] ZZ_J [0:63] = '{
        3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
        3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
        3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
        3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
        3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
        3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
    };

    localparam logic [1:0] PFX_SHORT = 2'b00;
    localparam logic [1:0] PFX_MID   = 2'b01;
    localparam logic [1:0] PFX_LONG  = 2'b10;
    localparam logic [2:0] PFX_RUN   = 3'b110;
    localparam logic [2:0] PFX_EOB   = 3'b111;

    localparam logic [5:0] LEN_SHORT = 6'd5;
    localparam logic [5:0] LEN_MID   = 6'd8;
    localparam logic [5:0] LEN_LONG  = 6'd11;
    localparam logic [5:0] LEN_RUN   = 6'd6;
    localparam logic [5:0] LEN_EOB   = 6'd3;

endpackage

// File: rtl/m3_lossless_decoder_bit_buffer.sv
// 32-bit MSB-first bit buffer: words append below the valid bits, codes consume from the top.
module m3_bit_buffer
    import m3_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_append_en,
    input  logic [15:0] i_append_word,
    input  logic        i_consume_en,
    input  logic [5:0]  i_consume_len,
    output logic [10:0] o_buf_top,
    output logic [5:0]  o_valid_bits
);

    logic [31:0] r_buf;
    logic [5:0]  r_valid;

    // Bits below r_valid are always zero, so appending is a plain OR
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf   <= '0;
            r_valid <= '0;
        end else if (i_append_en) begin
            r_buf   <= r_buf | ({i_append_word, 16'h0000} >> r_valid);
            r_valid <= r_valid + 6'd16;
        end else if (i_consume_en) begin
            r_buf   <= r_buf << i_consume_len;
            r_valid <= r_valid - i_consume_len;
        end
    end

    assign o_buf_top    = r_buf[31:21];
    assign o_valid_bits = r_valid;

endmodule

// File: rtl/m3_lossless_decoder.sv
// Decodes the variable-length coefficient bitstream, de-zigzags and dequantizes each
// 8x8 block, and writes 16-bit coefficients into the pre-IDCT SRAM region.
module m3_lossless_decoder
    import m3_pkg::*;
#(
    parameter int unsigned IMG_WIDTH         = 320,
    parameter int unsigned IMG_HEIGHT        = 240,
    parameter logic [17:0] BITSTREAM_BASE    = 18'd0,
    parameter logic [17:0] COEFF_BASE        = 18'd76800,
    parameter int unsigned SRAM_READ_LATENCY = 2
) (
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    input  logic        m3_start,
    input  logic [15:0] SRAM_read_data,
    output logic [15:0] SRAM_write_data,
    output logic [17:0] SRAM_address,
    output logic        write_en_n,
    output logic        m3_finish,
    output logic        decode_error
);

    localparam logic [5:0] LAST_BX   = 6'(IMG_WIDTH / 8 - 1);
    localparam logic [5:0] LAST_BY   = 6'(IMG_HEIGHT / 8 - 1);
    localparam logic [3:0] WAIT_LAST = 4'(SRAM_READ_LATENCY - 2);

    m3_state_type r_state, w_state_next;
    logic [17:0] r_rd_ptr, w_rd_ptr_next;
    logic [3:0]  r_wait, w_wait_next;
    logic [6:0]  r_k, w_k_next, w_k_inc;
    logic [5:0]  r_bx, w_bx_next, r_by, w_by_next;
    logic [15:0] r_pending_val, w_pending_val_next;
    logic [6:0]  r_pending_cnt, w_pending_cnt_next, w_cnt_dec;
    logic        r_decode_error, w_decode_error_next;

    logic        w_append_en, w_consume_en;
    logic [5:0]  w_consume_len, w_valid_bits;
    logic [10:0] w_top;
    logic [15:0] w_dec_val;
    logic [6:0]  w_dec_cnt;
    logic [5:0]  w_dec_len;
    logic [2:0]  w_i, w_j, w_shift;
    logic [17:0] w_row, w_col, w_wr_addr;
    logic [15:0] w_wr_data;

    m3_bit_buffer u_bit_buffer (
        .i_clk         (CLOCK_50_I),
        .i_rst         (Reset),
        .i_append_en   (w_append_en),
        .i_append_word (SRAM_read_data),
        .i_consume_en  (w_consume_en),
        .i_consume_len (w_consume_len),
        .o_buf_top     (w_top),
        .o_valid_bits  (w_valid_bits)
    );

    always_comb begin
        w_dec_val = '0;
        w_dec_cnt = 7'd1;
        w_dec_len = LEN_EOB;
        if (w_top[10:8] == PFX_EOB) begin
            w_dec_cnt = 7'd64 - r_k;
        end else if (w_top[10:8] == PFX_RUN) begin
            w_dec_cnt = (w_top[7:5] == 3'b000) ? 7'd8 : {4'b0000, w_top[7:5]};
            w_dec_len = LEN_RUN;
        end else if (w_top[10:9] == PFX_LONG) begin
            w_dec_val = {{7{w_top[8]}}, w_top[8:0]};
            w_dec_len = LEN_LONG;
        end else if (w_top[10:9] == PFX_MID) begin
            w_dec_val = {{10{w_top[8]}}, w_top[8:3]};
            w_dec_len = LEN_MID;
        end else begin
            w_dec_val = {{13{w_top[8]}}, w_top[8:6]};
            w_dec_len = LEN_SHORT;
        end
    end

    assign w_i       = ZZ_I[r_k[5:0]];
    assign w_j       = ZZ_J[r_k[5:0]];
    assign w_shift   = QSHIFT[{1'b0, w_i} + {1'b0, w_j}];
    assign w_row     = 18'(r_by) * 18'd8 + 18'(w_i);
    assign w_col     = 18'(r_bx) * 18'd8 + 18'(w_j);
    assign w_wr_addr = COEFF_BASE + w_row * 18'(IMG_WIDTH) + w_col;
    assign w_wr_data = r_pending_val << w_shift;
    assign w_k_inc   = r_k + 7'd1;
    assign w_cnt_dec = r_pending_cnt - 7'd1;

    always_comb begin
        w_state_next        = r_state;
        w_rd_ptr_next       = r_rd_ptr;
        w_wait_next         = r_wait;
        w_k_next            = r_k;
        w_bx_next           = r_bx;
        w_by_next           = r_by;
        w_pending_val_next  = r_pending_val;
        w_pending_cnt_next  = r_pending_cnt;
        w_decode_error_next = r_decode_error;
        w_append_en         = 1'b0;
        w_consume_en        = 1'b0;
        w_consume_len       = w_dec_len;
        SRAM_address        = '0;
        SRAM_write_data     = '0;
        write_en_n          = 1'b1;
        m3_finish           = 1'b0;

        unique case (r_state)
            S_M3_IDLE: begin
                if (m3_start) begin
                    w_rd_ptr_next = BITSTREAM_BASE;
                    w_k_next      = '0;
                    w_bx_next     = '0;
                    w_by_next     = '0;
                    // Drop bits left over from a previous image
                    w_consume_en  = 1'b1;
                    w_consume_len = w_valid_bits;
                    w_state_next  = S_M3_REQ;
                end
            end
            S_M3_REQ: begin
                SRAM_address  = r_rd_ptr;
                w_rd_ptr_next = r_rd_ptr + 18'd1;
                w_wait_next   = '0;
                w_state_next  = S_M3_WAIT;
            end
            S_M3_WAIT: begin
                if (r_wait == WAIT_LAST) w_state_next = S_M3_APPEND;
                else                     w_wait_next  = r_wait + 4'd1;
            end
            S_M3_APPEND: begin
                // Refills only happen below 16 bits, so one word always suffices
                w_append_en  = 1'b1;
                w_state_next = S_M3_DECODE;
            end
            S_M3_DECODE: begin
                w_consume_en       = 1'b1;
                w_pending_val_next = w_dec_val;
                w_pending_cnt_next = w_dec_cnt;
                w_state_next       = S_M3_WRITE;
            end
            S_M3_WRITE: begin
                write_en_n         = 1'b0;
                SRAM_address       = w_wr_addr;
                SRAM_write_data    = w_wr_data;
                w_k_next           = w_k_inc;
                w_pending_cnt_next = w_cnt_dec;
                if (w_cnt_dec == 7'd0) begin
                    if (w_k_inc == 7'd64)          w_state_next = S_M3_NEXT_BLOCK;
                    else if (w_valid_bits < 6'd16) w_state_next = S_M3_REQ;
                    else                           w_state_next = S_M3_DECODE;
                end else if (w_k_inc == 7'd64) begin
                    w_decode_error_next = 1'b1;
                    w_state_next        = S_M3_NEXT_BLOCK;
                end
            end
            S_M3_NEXT_BLOCK: begin
                w_k_next     = '0;
                w_state_next = (w_valid_bits < 6'd16) ? S_M3_REQ : S_M3_DECODE;
                if (r_bx == LAST_BX) begin
                    w_bx_next = '0;
                    if (r_by == LAST_BY) begin
                        w_by_next    = '0;
                        w_state_next = S_M3_DONE;
                    end else begin
                        w_by_next = r_by + 6'd1;
                    end
                end else begin
                    w_bx_next = r_bx + 6'd1;
                end
            end
            S_M3_DONE: begin
                m3_finish    = 1'b1;
                w_state_next = S_M3_IDLE;
            end
            default: w_state_next = S_M3_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            r_state        <= S_M3_IDLE;
            r_rd_ptr       <= '0;
            r_wait         <= '0;
            r_k            <= '0;
            r_bx           <= '0;
            r_by           <= '0;
            r_pending_val  <= '0;
            r_pending_cnt  <= '0;
            r_decode_error <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_rd_ptr       <= w_rd_ptr_next;
            r_wait         <= w_wait_next;
            r_k            <= w_k_next;
            r_bx           <= w_bx_next;
            r_by           <= w_by_next;
            r_pending_val  <= w_pending_val_next;
            r_pending_cnt  <= w_pending_cnt_next;
            r_decode_error <= w_decode_error_next;
        end
    end

    assign decode_error = r_decode_error;

endmodule

// File: tb/tb_m3_lossless_decoder.sv
// Scoreboard bench: directed bitstreams, expected SRAM writes queued and checked by a monitor.
module tb_m3_lossless_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic [17:0] addr;
    logic        wen_n;
    logic        finish;
    logic        derr;

    always #10 clk = ~clk;

    m3_lossless_decoder dut (
        .CLOCK_50_I      (clk),
        .Reset           (rst),
        .m3_start        (start),
        .SRAM_read_data  (rd_data),
        .SRAM_write_data (wr_data),
        .SRAM_address    (addr),
        .write_en_n      (wen_n),
        .m3_finish       (finish),
        .decode_error    (derr)
    );

    // Bitstream memory with a two-cycle read pipeline
    logic [15:0] mem [0:511];
    logic [15:0] r_d1;
    always @(posedge clk) begin
        r_d1    <= (addr < 18'd512) ? mem[addr[8:0]] : 16'h0000;
        rd_data <= r_d1;
    end

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t  exp_q [$];
    wr_t  cur;
    int   checks = 0;
    int   errors = 0;
    int   finish_cnt = 0;
    logic sbits [0:8191];
    int   spos = 0;

    // JPEG zigzag as natural-order position row*8+col
    int zz_pos [0:63] = '{
        0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    always @(negedge clk) begin
        if (!rst && !wen_n && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (addr !== cur.a || wr_data !== cur.d) begin
                errors++;
                $display("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                         addr, wr_data, cur.a, cur.d);
            end
        end
        if (!rst && finish) begin
            finish_cnt++;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL finish_early: %0d writes outstanding, expected 0", exp_q.size());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [15:0] code, input int len);
        for (int b = len - 1; b >= 0; b--) begin
            sbits[spos] = code[b];
            spos++;
        end
    endtask

    function automatic logic [17:0] eaddr(input int bx, input int by, input int k);
        int p;
        p = zz_pos[k];
        return 18'(76800 + (by * 8 + p / 8) * 320 + bx * 8 + p % 8);
    endfunction

    task automatic push(input int bx, input int by, input int k, input logic [15:0] d);
        wr_t e;
        e.a = eaddr(bx, by, k);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_zeros(input int bx, input int by, input int k0);
        for (int k = k0; k < 64; k++) push(bx, by, k, 16'h0000);
    endtask

    task automatic begin_test();
        rst   = 1'b1;
        start = 1'b0;
        spos  = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic launch();
        for (int w = 0; w < 512; w++) begin
            mem[w] = 16'h0000;
            for (int b = 0; b < 16; b++)
                if (w * 16 + b < spos) mem[w][15-b] = sbits[w*16+b];
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d writes pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_wdata", 32'(wr_data), 32'd0);
        check("reset_wen_n", 32'(wen_n), 32'd1);
        check("reset_finish", 32'(finish), 32'd0);
        check("reset_error", 32'(derr), 32'd0);

        // All-zero stream; a mid-run start pulse must be ignored
        begin_test();
        push_zeros(0, 0, 0);
        push(1, 0, 0, 16'h0000);
        launch();
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("zero_stream", 2000);
        check("zero_stream_error", 32'(derr), 32'd0);

        // 00 011, 01 111111, 111
        begin_test();
        put(16'h1BFF, 16);
        push(0, 0, 0, 16'd24);
        push(0, 0, 1, 16'hFFFC);
        push_zeros(0, 0, 2);
        push(1, 0, 0, 16'h0000);
        launch();
        wait_drain("short_mid_eob", 2000);

        // 9-bit extremes in consecutive blocks
        begin_test();
        put(16'b10011111111, 11);
        put(16'b111, 3);
        put(16'b10100000000, 11);
        put(16'b111, 3);
        push(0, 0, 0, 16'd2040);
        push_zeros(0, 0, 1);
        push(1, 0, 0, 16'hF800);
        push_zeros(1, 0, 1);
        push(2, 0, 0, 16'h0000);
        launch();
        wait_drain("long_codes", 3000);

        // Eight full runs exactly fill a block; next run lands in block 1
        begin_test();
        for (int r = 0; r < 8; r++) put(16'b110000, 6);
        put(16'b110001, 6);
        push_zeros(0, 0, 0);
        push(1, 0, 0, 16'h0000);
        push(1, 0, 1, 16'h0000);
        launch();
        wait_drain("exact_runs", 2000);
        check("exact_runs_error", 32'(derr), 32'd0);

        // Run overflows the block end: truncated and flagged
        begin_test();
        put(16'b00001, 5);
        for (int r = 0; r < 8; r++) put(16'b110000, 6);
        push(0, 0, 0, 16'd8);
        push_zeros(0, 0, 1);
        push(1, 0, 0, 16'h0000);
        launch();
        wait_drain("overflow", 2000);
        check("overflow_error", 32'(derr), 32'd1);
        repeat (100) @(negedge clk);
        check("overflow_error_sticky", 32'(derr), 32'd1);

        // Asynchronous reset mid-run
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrun_addr", 32'(addr), 32'd0);
        check("midrun_wdata", 32'(wr_data), 32'd0);
        check("midrun_wen_n", 32'(wen_n), 32'd1);
        check("midrun_finish", 32'(finish), 32'd0);
        check("midrun_error", 32'(derr), 32'd0);

        // Full image of end-of-block codes
        begin_test();
        for (int w = 0; w < 225; w++) put(16'hFFFF, 16);
        for (int by = 0; by < 30; by++)
            for (int bx = 0; bx < 40; bx++)
                push_zeros(bx, by, 0);
        finish_cnt = 0;
        launch();
        wait_drain("full_image", 90000);
        for (int n = 0; n < 10 && finish_cnt == 0; n++) @(negedge clk);
        repeat (50) @(negedge clk);
        check("finish_pulses", 32'(finish_cnt), 32'd1);
        check("full_image_error", 32'(derr), 32'd0);
        check("idle_wen_n", 32'(wen_n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
